// File: rtl/uart_pkg.sv
// Shared UART definitions for the pinwheel serial blocks.
// - uart_rx_state_e : receiver state encoding
// - cycles_per_bit  : core clocks per serial bit, also used by the transmitter
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_e;

  function automatic int unsigned cycles_per_bit(input int unsigned clock_rate,
                                                 input int unsigned baud_rate);
    return clock_rate / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Ports:
//   clock  - destination clock
//   reset  - synchronous, active-high; both flops load reset_value
//   d_i    - asynchronous input
//   q_o    - synchronised output (second flop)
module sync_2ff #(
  parameter bit reset_value = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= reset_value;
      sync_q <= reset_value;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pinwheel_uart_rx.sv
// 8N1 serial receiver (LSB first) with a one-entry valid/ready output buffer.
// Ports:
//   clock, reset  - core clock; synchronous active-high reset
//   ser_rx        - asynchronous serial line, idle high
//   o_data        - received byte, valid while o_valid
//   o_valid       - buffer holds an unconsumed byte
//   i_ready       - consumer takes o_data when o_valid && i_ready
//   o_frame_err   - one-cycle pulse: stop bit sampled low
//   o_overrun     - one-cycle pulse: completed byte dropped, buffer full
//   o_busy        - receiver is not idle
module pinwheel_uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned clock_rate = 24000000,
  parameter int unsigned baud_rate  = 1200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ser_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int unsigned cycles_per_bit = uart_pkg::cycles_per_bit(clock_rate, baud_rate);
  localparam int unsigned half_bit       = cycles_per_bit / 2;
  localparam int unsigned timer_w        = $clog2(cycles_per_bit);

  localparam logic [timer_w-1:0] half_load = timer_w'(half_bit - 1);
  localparam logic [timer_w-1:0] bit_load  = timer_w'(cycles_per_bit - 1);

  if (cycles_per_bit < 4) begin : gen_cfg_check
    $error("pinwheel_uart_rx: cycles_per_bit must be at least 4");
  end

  logic rx_s;

  sync_2ff #(
    .reset_value(1'b1)
  ) u_sync_rx (
    .clock(clock),
    .reset(reset),
    .d_i  (ser_rx),
    .q_o  (rx_s)
  );

  uart_rx_state_e     state_q, state_d;
  logic [timer_w-1:0] timer_q, timer_d;
  logic [7:0]         shift_q, shift_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;

  logic tick;
  logic deliver;
  logic stop_bad;

  assign tick = (state_q != IDLE) && (timer_q == '0);

  // Receive state machine and bit timer.
  always_comb begin
    state_d   = state_q;
    timer_d   = (timer_q != '0) ? timer_q - timer_w'(1) : timer_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    deliver   = 1'b0;
    stop_bad  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          // First sample lands mid start bit.
          timer_d = half_load;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            timer_d   = bit_load;
            bit_idx_d = 3'd0;
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_d   = {rx_s, shift_q[7:1]};
          timer_d   = bit_load;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (rx_s) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // Wait out a break so it reports only one error.
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output buffer: a delivery wins over a same-cycle consume.
  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;
    frame_err_d = stop_bad;

    if (deliver) begin
      if (!valid_q || i_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_pinwheel_uart_rx.sv
// Bench for pinwheel_uart_rx at 16 clocks per bit. Frames are driven on the
// line; a frame-level model predicts delivered bytes, frame errors and
// overruns, and a monitor checks every handshake and pulse against it.
module tb_pinwheel_uart_rx;

  localparam int unsigned CPB = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ser_rx = 1'b1;
  logic       i_ready = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  always #5 clock = ~clock;

  pinwheel_uart_rx #(
    .clock_rate(16),
    .baud_rate (1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ser_rx     (ser_rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun),
    .o_busy     (o_busy)
  );

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] byte_q[$];
  int         ferr_exp = 0;
  int         ovr_exp = 0;
  bit         mdl_full = 1'b0;
  logic [7:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: what the consumer should see for one frame.
  task automatic predict(input logic [7:0] b, input bit stop_ok, input bit rdy_at_stop,
                         input bit rdy_after);
    if (!stop_ok) begin
      ferr_exp++;
    end else if (mdl_full && !rdy_at_stop) begin
      ovr_exp++;
    end else begin
      byte_q.push_back(b);
      mdl_full = 1'b1;
    end
    if (rdy_after) mdl_full = 1'b0;
  endtask

  // Monitor: every handshake, error pulse and overrun pulse must be predicted.
  always @(negedge clock) begin
    if (!reset) begin
      if (o_valid && i_ready) begin
        vectors++;
        if (byte_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_byte: got %02h, expected no byte", o_data);
        end else begin
          mon_exp = byte_q.pop_front();
          if (o_data !== mon_exp) begin
            miscompares++;
            $display("FAIL rx_byte: got %02h, expected %02h", o_data, mon_exp);
          end
        end
      end
      if (o_frame_err) begin
        vectors++;
        if (ferr_exp == 0) begin
          miscompares++;
          $display("FAIL unexpected_frame_err: got pulse, expected none");
        end else begin
          ferr_exp--;
        end
      end
      if (o_overrun) begin
        vectors++;
        if (ovr_exp == 0) begin
          miscompares++;
          $display("FAIL unexpected_overrun: got pulse, expected none");
        end else begin
          ovr_exp--;
        end
      end
    end
  end

  // All line-driving tasks start and end 1 time unit after a rising edge.
  task automatic drive_bit(input logic v);
    ser_rx = v;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    ser_rx = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #(10 * 80000);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    bit         rstop;
    int         cyc;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_data", o_data, 8'h00);
    check("rst_valid", o_valid, 1'b0);
    check("rst_frame_err", o_frame_err, 1'b0);
    check("rst_overrun", o_overrun, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    @(posedge clock);
    #1 reset = 1'b0;
    idle(5);
    check("post_rst_busy", o_busy, 1'b0);

    // 0xA5 with latency and one-cycle valid
    i_ready = 1'b1;
    predict(8'hA5, 1'b1, 1'b1, 1'b1);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        cyc = 0;
        while (!o_valid && cyc < 400) begin
          @(posedge clock);
          cyc++;
          @(negedge clock);
        end
        check("a5_latency", cyc, 155);
        @(negedge clock);
        check("a5_valid_one_cycle", o_valid, 1'b0);
      end
    join
    idle(10);

    // Glitch shorter than half a bit, then a real frame
    ser_rx = 1'b0;
    repeat (4) @(posedge clock);
    #1 ser_rx = 1'b1;
    check("glitch_busy", o_busy, 1'b1);
    repeat (12) @(posedge clock);
    #1;
    check("glitch_rejected", o_busy, 1'b0);
    predict(8'h3C, 1'b1, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(10);

    // Bad stop bit followed by a held break
    predict(8'h55, 1'b0, 1'b1, 1'b1);
    send_frame(8'h55, 1'b0);
    ser_rx = 1'b0;
    repeat (40) @(posedge clock);
    #1;
    check("break_busy", o_busy, 1'b1);
    idle(10);
    check("break_released", o_busy, 1'b0);
    predict(8'h01, 1'b1, 1'b1, 1'b1);
    send_frame(8'h01, 1'b1);
    idle(10);

    // Overrun with consumer stalled
    i_ready = 1'b0;
    predict(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h11, 1'b1);
    idle(4);
    predict(8'h22, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1);
    idle(4);
    check("ovr_hold_data", o_data, 8'h11);
    check("ovr_hold_valid", o_valid, 1'b1);
    i_ready = 1'b1;
    mdl_full = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("ovr_valid_fall", o_valid, 1'b0);
    idle(4);

    // Consume in the same cycle the next byte completes
    i_ready = 1'b0;
    predict(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h11, 1'b1);
    idle(4);
    predict(8'h22, 1'b1, 1'b1, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (154) @(posedge clock);
        #1 i_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("swap_valid", o_valid, 1'b1);
        check("swap_data", o_data, 8'h22);
      end
    join
    idle(10);

    // Reset during data bit 3 abandons the frame silently
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    ser_rx = 1'b1;
    repeat (8) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    check("midrst_data", o_data, 8'h00);
    check("midrst_valid", o_valid, 1'b0);
    check("midrst_busy", o_busy, 1'b0);
    check("midrst_frame_err", o_frame_err, 1'b0);
    idle(20);
    check("midrst_still_idle", o_busy, 1'b0);
    predict(8'hC3, 1'b1, 1'b1, 1'b1);
    send_frame(8'hC3, 1'b1);
    idle(10);

    // Random frames, some back-to-back, some with a bad stop bit
    for (int n = 0; n < 24; n++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 7) != 0);
      predict(rb, rstop, 1'b1, 1'b1);
      send_frame(rb, rstop);
      if (!rstop) idle($urandom_range(4, 8));
      else idle($urandom_range(0, 5));
    end

    idle(40);
    check("leftover_bytes", byte_q.size(), 0);
    check("leftover_frame_err", ferr_exp, 0);
    check("leftover_overrun", ovr_exp, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
